pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl_prio.sv | 23 ++
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: per-register ctrl encodings
// and the flush FSM state type.
package pipe_ctrl_pkg;

  localparam logic [1:0] CTRL_PASS   = 2'b00;
  localparam logic [1:0] CTRL_HOLD   = 2'b01;
  localparam logic [1:0] CTRL_BUBBLE = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PEND  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// Highest-set-bit priority encoder over the per-stage stall requests.
module pipe_ctrl_prio #(
  parameter int NSTAGE = 5,
  parameter int IDXW   = 3
) (
  input  logic [NSTAGE-1:0] i_stall,
  output logic              o_valid,
  output logic [IDXW-1:0]   o_idx
);

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (i_stall[i]) begin
        o_valid = 1'b1;
        o_idx   = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with stall watchdog.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE      = 5,
  parameter int FLUSH_STAGE = 2,
  parameter int FLUSH_LEN   = 1,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSTAGE-1:0]     stall_req,
  input  logic                  flush_req,
  output logic [2*NSTAGE-1:0]   ctrl,
  output logic                  flush_pending,
  output logic                  stall_timeout,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);

  localparam int IDXW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int IW1  = IDXW + 1;
  localparam logic [NSTAGE-1:0] LOW_MASK = {NSTAGE{1'b1}} >> (NSTAGE - 1 - FLUSH_STAGE);

  state_t            r_state;
  logic [3:0]        r_flushCnt;
  logic [15:0]       r_wdog;
  logic              r_timeout;

  logic              w_stallAny;
  logic              w_stallAbove;
  logic              w_accept;
  logic              w_apply;
  logic [NSTAGE-1:0] w_stallEff;
  logic              w_valid;
  logic [IDXW-1:0]   w_idx;
  logic [IW1-1:0]    w_idxExt;
  logic [15:0]       w_wdNext;
  logic              w_toHit;

  assign w_stallAny   = |stall_req;
  assign w_stallAbove = |(stall_req & ~LOW_MASK);

  // w_accept marks the first applied cycle of a flush; FLUSH cycles continue it.
  assign w_accept = rst && !w_stallAbove &&
                    (((r_state == ST_IDLE) && flush_req) || (r_state == ST_PEND));
  assign w_apply  = w_accept || (rst && (r_state == ST_FLUSH));

  assign w_stallEff = w_apply ? (stall_req & ~LOW_MASK) : stall_req;

  pipe_ctrl_prio #(
    .NSTAGE (NSTAGE),
    .IDXW   (IDXW)
  ) u_prio (
    .i_stall (w_stallEff),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_idxExt = {1'b0, w_idx};

  always_comb begin
    ctrl = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      ctrl[2*i +: 2] = CTRL_PASS;
      if (w_valid && (IW1'(i) <= w_idxExt)) begin
        ctrl[2*i +: 2] = CTRL_HOLD;
      end else if (w_valid && (IW1'(i) == w_idxExt + IW1'(1))) begin
        ctrl[2*i +: 2] = CTRL_BUBBLE;
      end
      if (w_apply) begin
        if (i == 0) begin
          ctrl[2*i +: 2] = CTRL_PASS;
        end else if (i <= FLUSH_STAGE) begin
          ctrl[2*i +: 2] = CTRL_BUBBLE;
        end
      end
      if (!rst) begin
        ctrl[2*i +: 2] = CTRL_PASS;
      end
    end
  end

  assign w_wdNext = !w_stallAny ? 16'd0 :
                    (r_wdog == 16'hFFFF) ? r_wdog : r_wdog + 16'd1;
  assign w_toHit  = w_stallAny && (w_wdNext == 16'(TIMEOUT));

  assign flush_pending = rst && (r_state == ST_PEND);
  assign stall_timeout = rst && (r_timeout || w_toHit);

  // A flush_req seen in PEND or FLUSH merges into the flush already in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_flushCnt <= 4'd0;
      r_wdog     <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_wdog <= w_wdNext;
      if (w_toHit) begin
        r_timeout <= 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_PEND: begin
          if (w_accept) begin
            r_flushCnt <= 4'(FLUSH_LEN - 1);
            r_state    <= (FLUSH_LEN == 1) ? ST_IDLE : ST_FLUSH;
          end else if (flush_req) begin
            r_state <= ST_PEND;
          end
        end
        ST_FLUSH: begin
          if (flush_req) begin
            r_flushCnt <= 4'(FLUSH_LEN);
          end else if (r_flushCnt <= 4'd1) begin
            r_flushCnt <= 4'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_flushCnt <= r_flushCnt - 4'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_flushCnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perfStall;
  logic [31:0] r_perfFlush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perfStall <= 32'd0;
      r_perfFlush <= 32'd0;
    end else begin
      if (w_stallAny) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
      if (w_accept) begin
        r_perfFlush <= r_perfFlush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perfStall;
  assign perf_flush_cnt = r_perfFlush;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (NSTAGE=5, FLUSH_STAGE=2, FLUSH_LEN=3, TIMEOUT=4).
module tb_pipe_ctrl;

  typedef struct {
    logic [4:0] stall;
    logic       flush;
    logic [9:0] expCtrl;
    logic       expPend;
    logic       expTo;
  } vec_t;

  typedef struct {
    logic [9:0] ctrl;
    logic       pend;
    logic       to;
    string      tag;
  } exp_t;

  localparam logic [9:0] C_ALLP = 10'b00_00_00_00_00;
  localparam logic [9:0] C_ALLH = 10'b01_01_01_01_01;
  localparam logic [9:0] C_S0   = 10'b00_00_00_10_01;
  localparam logic [9:0] C_S1   = 10'b00_00_10_01_01;
  localparam logic [9:0] C_S2   = 10'b00_10_01_01_01;
  localparam logic [9:0] C_S3   = 10'b10_01_01_01_01;
  localparam logic [9:0] C_FL   = 10'b00_00_10_10_00;
  localparam logic [9:0] C_FLS3 = 10'b10_01_10_10_00;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  stall_req;
  logic        flush_req;
  logic [9:0]  ctrl;
  logic        flush_pending;
  logic        stall_timeout;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int   total;
  int   bad;
  int   expStall;
  int   expFlush;
  exp_t expQ[$];
  exp_t chkE;
  vec_t vecs[12];

  pipe_ctrl #(
    .NSTAGE      (5),
    .FLUSH_STAGE (2),
    .FLUSH_LEN   (3),
    .TIMEOUT     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req      (stall_req),
    .flush_req      (flush_req),
    .ctrl           (ctrl),
    .flush_pending  (flush_pending),
    .stall_timeout  (stall_timeout),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs that cycle must show.
  task automatic applyStimulus(input logic r, input logic [4:0] s, input logic f,
                               input logic [9:0] c, input logic p, input logic t,
                               input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    stall_req = s;
    flush_req = f;
    if (!r) begin
      expStall = 0;
      expFlush = 0;
    end else if (s != 5'b0) begin
      expStall++;
    end
    e.ctrl = c;
    e.pend = p;
    e.to   = t;
    e.tag  = tag;
    expQ.push_back(e);
  endtask

  task automatic checkPerf(input string tag);
    @(posedge clk);
    #2;
    check({tag, "_perf_stall"}, perf_stall_cnt, PERF_ON ? 32'(expStall) : 32'd0);
    check({tag, "_perf_flush"}, perf_flush_cnt, PERF_ON ? 32'(expFlush) : 32'd0);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      chkE = expQ.pop_front();
      check({chkE.tag, "_ctrl"}, 32'(ctrl), 32'(chkE.ctrl));
      check({chkE.tag, "_pend"}, 32'(flush_pending), 32'(chkE.pend));
      check({chkE.tag, "_timeout"}, 32'(stall_timeout), 32'(chkE.to));
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    expStall  = 0;
    expFlush  = 0;
    rst       = 1'b0;
    stall_req = 5'b0;
    flush_req = 1'b0;

    vecs[0]  = '{5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0};
    vecs[1]  = '{5'b00100, 1'b0, C_S2,   1'b0, 1'b0};
    vecs[2]  = '{5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0};
    vecs[3]  = '{5'b00001, 1'b0, C_S0,   1'b0, 1'b0};
    vecs[4]  = '{5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0};
    vecs[5]  = '{5'b01000, 1'b0, C_S3,   1'b0, 1'b0};
    vecs[6]  = '{5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0};
    vecs[7]  = '{5'b00010, 1'b0, C_S1,   1'b0, 1'b0};
    vecs[8]  = '{5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0};
    vecs[9]  = '{5'b10001, 1'b0, C_ALLH, 1'b0, 1'b0};
    vecs[10] = '{5'b00110, 1'b0, C_S2,   1'b0, 1'b0};
    vecs[11] = '{5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0};

    repeat (3) applyStimulus(1'b0, 5'b11111, 1'b1, C_ALLP, 1'b0, 1'b0, "reset");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0, "post_reset");
    checkPerf("reset");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].stall, vecs[i].flush, vecs[i].expCtrl,
                    vecs[i].expPend, vecs[i].expTo, $sformatf("vec%0d", i));
    end
    checkPerf("table");

    // Flush blocked by a stall above the flush boundary, then applied for 3 cycles.
    applyStimulus(1'b1, 5'b01000, 1'b1, C_S3,   1'b0, 1'b0, "pend_c1");
    applyStimulus(1'b1, 5'b01000, 1'b1, C_S3,   1'b1, 1'b0, "pend_c2");
    applyStimulus(1'b1, 5'b01000, 1'b0, C_S3,   1'b1, 1'b0, "pend_c3");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_FL,   1'b1, 1'b0, "pend_c4");
    expFlush++;
    applyStimulus(1'b1, 5'b00000, 1'b0, C_FL,   1'b0, 1'b0, "pend_c5");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_FL,   1'b0, 1'b0, "pend_c6");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0, "pend_c7");
    checkPerf("pend");

    // Immediate flush re-triggered on its 2nd cycle: five flush cycles, one count.
    applyStimulus(1'b1, 5'b00000, 1'b1, C_FL,   1'b0, 1'b0, "merge_c1");
    expFlush++;
    applyStimulus(1'b1, 5'b00000, 1'b1, C_FL,   1'b0, 1'b0, "merge_c2");
    applyStimulus(1'b1, 5'b00010, 1'b0, C_FL,   1'b0, 1'b0, "merge_c3");
    applyStimulus(1'b1, 5'b01000, 1'b0, C_FLS3, 1'b0, 1'b0, "merge_c4");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_FL,   1'b0, 1'b0, "merge_c5");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0, "merge_c6");
    checkPerf("merge");

    // Watchdog: four stalled cycles raise the sticky flag on the fourth.
    applyStimulus(1'b1, 5'b00001, 1'b0, C_S0,   1'b0, 1'b0, "wd_c1");
    applyStimulus(1'b1, 5'b00001, 1'b0, C_S0,   1'b0, 1'b0, "wd_c2");
    applyStimulus(1'b1, 5'b00001, 1'b0, C_S0,   1'b0, 1'b0, "wd_c3");
    applyStimulus(1'b1, 5'b00001, 1'b0, C_S0,   1'b0, 1'b1, "wd_c4");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_ALLP, 1'b0, 1'b1, "wd_c5");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_ALLP, 1'b0, 1'b1, "wd_c6");
    checkPerf("wd");

    // Reset while a flush is pending discards it and clears the watchdog flag.
    applyStimulus(1'b1, 5'b01000, 1'b1, C_S3,   1'b0, 1'b1, "rstpend_c1");
    applyStimulus(1'b1, 5'b01000, 1'b0, C_S3,   1'b1, 1'b1, "rstpend_c2");
    applyStimulus(1'b0, 5'b01000, 1'b0, C_ALLP, 1'b0, 1'b0, "rstpend_c3");
    applyStimulus(1'b0, 5'b01000, 1'b1, C_ALLP, 1'b0, 1'b0, "rstpend_c4");
    applyStimulus(1'b1, 5'b00100, 1'b0, C_S2,   1'b0, 1'b0, "rstpend_c5");
    applyStimulus(1'b1, 5'b00000, 1'b0, C_ALLP, 1'b0, 1'b0, "rstpend_c6");
    checkPerf("rstpend");

    @(negedge clk);
    @(negedge clk);
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
